alu_exec_ctrl: RTL and testbench

Two-stage execute controller sitting directly upstream of the combinational `alu`. It accepts register-to-register or register-immediate commands over a valid/ready handshake, reads operands from a 16×32 register file, drives `operation`/`operand1`/`operand2` into the ALU, registers the result and writes it back. Hazards are handled by write-back forwarding plus a one-cycle stall.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_regfile.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, widths and opcode helpers shared by the ALU
// and its execute controller.
package alu_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_NREG   = 16;
  localparam int ALU_REG_W  = 4;
  localparam int ALU_IMM_W  = 16;
  localparam int ALU_CNT_W  = 16;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SHRA = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_LT   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_GT   = 4'd9;

  // Opcodes above ALU_GT have no ALU function.
  function automatic logic op_is_legal(
    input logic [ALU_OP_W-1:0] op
  );
    return op <= ALU_GT;
  endfunction

  // Arithmetic and compare ops take a sign-extended immediate.
  function automatic logic op_imm_signed(
    input logic [ALU_OP_W-1:0] op
  );
    logic s;
    s = 1'b0;
    unique case (1'b1)
      (op == ALU_ADD): s = 1'b1;
      (op == ALU_SUB): s = 1'b1;
      (op == ALU_LT):  s = 1'b1;
      (op == ALU_GT):  s = 1'b1;
      default:         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register array with two operand ports, one debug port
// and one write port; entry 0 always reads as zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREG   = ALU_NREG,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  // Clear on reset; writes to entry 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous reads see the pre-write value in the write cycle.
  always_comb begin
    rdata1_o   = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    rdata2_o   = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
    dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: two-stage execute controller in front of the alu.
// Accept/operand read -> EX (drives ALU) -> WB (writes regfile).
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREG   = ALU_NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ALU_OP_W-1:0]  cmd_op,
  input  logic [ALU_REG_W-1:0] cmd_rd,
  input  logic [ALU_REG_W-1:0] cmd_rs1,
  input  logic [ALU_REG_W-1:0] cmd_rs2,
  input  logic                 cmd_imm_en,
  input  logic [ALU_IMM_W-1:0] cmd_imm,
  output logic [ALU_OP_W-1:0]  alu_operation,
  output logic [DATA_W-1:0]    alu_operand1,
  output logic [DATA_W-1:0]    alu_operand2,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 wb_valid,
  output logic [ALU_REG_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  input  logic [ALU_REG_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic                 err_illegal,
  output logic [ALU_CNT_W-1:0] retire_count
);

  typedef struct packed {
    logic                 valid;
    logic [ALU_OP_W-1:0]  op;
    logic [ALU_REG_W-1:0] rd;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
  } ex_t;

  typedef struct packed {
    logic                 valid;
    logic [ALU_REG_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_t;

  ex_t ex_q, ex_d;
  wb_t wb_q, wb_d;
  logic err_q, err_d;
  logic [ALU_CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] rf_rs1, rf_rs2;
  logic [DATA_W-1:0] imm_ext, opa, opb;
  logic cmd_legal, haz1, haz2;
  logic fwd1, fwd2, stall, fire;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (ALU_REG_W)
  ) u_rf (
    .clk        (clk),
    .reset      (reset),
    .we_i       (wb_q.valid),
    .waddr_i    (wb_q.rd),
    .wdata_i    (wb_q.data),
    .raddr1_i   (cmd_rs1),
    .raddr2_i   (cmd_rs2),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rf_rs1),
    .rdata2_o   (rf_rs2),
    .dbg_data_o (dbg_data)
  );

  // Stall only when EX still owes a result to a source we read;
  // illegal commands skip the hazard check entirely.
  always_comb begin
    cmd_legal = op_is_legal(cmd_op);
    haz1 = ex_q.valid && op_is_legal(ex_q.op)
        && (ex_q.rd != '0) && (cmd_rs1 == ex_q.rd);
    haz2 = ex_q.valid && op_is_legal(ex_q.op)
        && (ex_q.rd != '0) && !cmd_imm_en
        && (cmd_rs2 == ex_q.rd);
    stall = cmd_valid && cmd_legal && (haz1 || haz2);
    cmd_ready = !stall;
    fire = cmd_valid && cmd_ready;
  end

  // Operand select: WB bypass beats the array; r0 never bypasses.
  always_comb begin
    fwd1 = wb_q.valid && (wb_q.rd != '0)
        && (cmd_rs1 == wb_q.rd);
    fwd2 = wb_q.valid && (wb_q.rd != '0)
        && (cmd_rs2 == wb_q.rd);
    if (op_is_signed_imm()) begin
      imm_ext = {{(DATA_W-ALU_IMM_W){cmd_imm[ALU_IMM_W-1]}},
                 cmd_imm};
    end else begin
      imm_ext = {{(DATA_W-ALU_IMM_W){1'b0}}, cmd_imm};
    end
    opa = fwd1 ? wb_q.data : rf_rs1;
    if (cmd_imm_en) begin
      opb = imm_ext;
    end else begin
      opb = fwd2 ? wb_q.data : rf_rs2;
    end
  end

  function automatic logic op_is_signed_imm();
    return op_imm_signed(cmd_op);
  endfunction

  // Next state: EX keeps its operands when idle so the ALU inputs hold.
  always_comb begin
    ex_d = ex_q;
    ex_d.valid = 1'b0;
    if (fire && cmd_legal) begin
      ex_d.valid = 1'b1;
      ex_d.op    = cmd_op;
      ex_d.rd    = cmd_rd;
      ex_d.a     = opa;
      ex_d.b     = opb;
    end
    wb_d = wb_q;
    wb_d.valid = ex_q.valid;
    if (ex_q.valid) begin
      wb_d.rd   = ex_q.rd;
      wb_d.data = alu_result;
    end
    err_d = err_q | (fire && !cmd_legal);
    cnt_d = cnt_q + {{(ALU_CNT_W-1){1'b0}}, wb_q.valid};
  end

  // Pipeline, flag and counter registers; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      wb_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      wb_q  <= wb_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Output wiring.
  always_comb begin
    alu_operation = ex_q.op;
    alu_operand1  = ex_q.a;
    alu_operand2  = ex_q.b;
    wb_valid      = wb_q.valid;
    wb_rd         = wb_q.rd;
    wb_data       = wb_q.data;
    err_illegal   = err_q;
    retire_count  = cnt_q;
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized and directed checks of alu_exec_ctrl
// against an architectural (sequential) register-file model.
module tb_alu_exec_ctrl;

  typedef struct packed {
    int          cyc;
    logic [3:0]  rd;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [3:0]  alu_operation;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        err_illegal;
  logic [15:0] retire_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  logic [31:0] rf [16];
  int          retired;
  logic        err_m;
  logic        last_live;
  int          last_cyc;
  logic [3:0]  last_rd;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rd        (cmd_rd),
    .cmd_rs1       (cmd_rs1),
    .cmd_rs2       (cmd_rs2),
    .cmd_imm_en    (cmd_imm_en),
    .cmd_imm       (cmd_imm),
    .alu_operation (alu_operation),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_result    (alu_result),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .err_illegal   (err_illegal),
    .retire_count  (retire_count)
  );

  function automatic logic [31:0] alu_model(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b
  );
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return (a > b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_model(
    input logic [3:0] op, input logic [15:0] imm
  );
    if (op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9)
      return {{16{imm[15]}}, imm};
    return {16'h0, imm};
  endfunction

  // Environment ALU.
  assign alu_result = alu_model(alu_operation, alu_operand1, alu_operand2);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      mon_e.cyc  = cyc;
      mon_e.rd   = wb_rd;
      mon_e.data = wb_data;
      obs_q.push_back(mon_e);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
    retired   = 0;
    err_m     = 1'b0;
    last_live = 1'b0;
    last_cyc  = -10;
    last_rd   = 4'd0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(
    input logic [3:0] op, input logic [3:0] rd,
    input logic [3:0] rs1, input logic [3:0] rs2,
    input logic ie, input logic [15:0] imm,
    output int stalls, output int exp_stalls
  );
    logic acc;
    int c;
    logic [31:0] a, b, r;
    ev_t e;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd;
    cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = ie; cmd_imm = imm;
    stalls = 0; exp_stalls = 0; acc = 1'b0; c = 0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk);
      if (t == 0) begin
        exp_stalls = (last_live && last_cyc == cyc - 1
          && last_rd != 4'd0 && op <= 4'd9
          && (rs1 == last_rd || (!ie && rs2 == last_rd))) ? 1 : 0;
      end
      if (cmd_ready === 1'b1) begin
        acc = 1'b1;
        c = cyc;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      if (op <= 4'd9) begin
        a = rf[rs1];
        b = ie ? imm_model(op, imm) : rf[rs2];
        r = alu_model(op, a, b);
        e.cyc = c + 2; e.rd = rd; e.data = r;
        exp_q.push_back(e);
        if (rd != 4'd0) rf[rd] = r;
        retired++;
        last_live = 1'b1; last_cyc = c; last_rd = rd;
      end else begin
        err_m = 1'b1;
        last_live = 1'b0;
      end
    end
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0;
    cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
    n_tests++;
    if ({wb_valid, wb_rd, wb_data} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_wb got %b/%h/%h want 0", wb_valid, wb_rd, wb_data);
    end
    n_tests++;
    if (err_illegal !== 1'b0 || retire_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_flags got err=%b cnt=%0d want 0/0", err_illegal, retire_count);
    end
    n_tests++;
    if ({alu_operation, alu_operand1, alu_operand2} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_alu got %h %h %h want 0", alu_operation, alu_operand1, alu_operand2);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      @(negedge clk);
      n_tests++;
      if (dbg_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg r%0d got %h want 0", i, dbg_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int s, es;
    ev_t o, x;
    issue(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005, s, es);
    issue(4'd0, 4'd2, 4'd0, 4'd0, 1'b1, 16'hFFFD, s, es);
    issue(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0000, s, es);
    n_tests++;
    if (s !== 1) begin
      n_fail++; $display("FAIL dep_stall got %0d want 1", s);
    end
    issue(4'd4, 4'd7, 4'd1, 4'd0, 1'b1, 16'h0003, s, es);
    issue(4'd7, 4'd4, 4'd2, 4'd0, 1'b1, 16'h0001, s, es);
    n_tests++;
    if (s !== 0) begin
      n_fail++; $display("FAIL nodep_stall got %0d want 0", s);
    end
    issue(4'd6, 4'd5, 4'd2, 4'd0, 1'b1, 16'h0001, s, es);
    issue(4'd8, 4'd6, 4'd2, 4'd1, 1'b0, 16'h0000, s, es);
    drain();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL dir_wb_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL dir_wb got c%0d r%0d %h want c%0d r%0d %h", o.cyc, o.rd, o.data, x.cyc, x.rd, x.data);
      end
    end
    obs_q.delete(); exp_q.delete();
    dbg_addr = 4'd2; #1;
    n_tests++;
    if (dbg_data !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL dbg_r2 got %h want fffffffd", dbg_data);
    end
    dbg_addr = 4'd3; #1;
    n_tests++;
    if (dbg_data !== 32'h2) begin
      n_fail++; $display("FAIL dbg_r3 got %h want 2", dbg_data);
    end
    dbg_addr = 4'd5; #1;
    n_tests++;
    if (dbg_data !== 32'h7FFFFFFE) begin
      n_fail++; $display("FAIL dbg_r5 got %h want 7ffffffe", dbg_data);
    end
    dbg_addr = 4'd6; #1;
    n_tests++;
    if (dbg_data !== 32'h0) begin
      n_fail++; $display("FAIL dbg_r6 got %h want 0", dbg_data);
    end
    n_tests++;
    if (retire_count !== 16'd7) begin
      n_fail++; $display("FAIL dir_retire got %0d want 7", retire_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int s, es;
    issue(4'd12, 4'd9, 4'd1, 4'd2, 1'b0, 16'h0000, s, es);
    drain();
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL illegal_wb got %0d events want 0", obs_q.size());
    end
    n_tests++;
    if (err_illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_err got %b want 1", err_illegal);
    end
    n_tests++;
    if (retire_count !== 16'(retired)) begin
      n_fail++; $display("FAIL illegal_retire got %0d want %0d", retire_count, retired);
    end
    issue(4'd0, 4'd9, 4'd1, 4'd0, 1'b1, 16'h0001, s, es);
    drain();
    obs_q.delete(); exp_q.delete();
    n_tests++;
    if (err_illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky got %b want 1", err_illegal);
    end
  endtask

  task automatic test_r0_write();
    int s, es;
    ev_t o;
    issue(4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 16'hFFFF, s, es);
    drain();
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL r0_wb_count got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      n_tests++;
      if (o.rd !== 4'd0 || o.data !== 32'h0000FFFF) begin
        n_fail++; $display("FAIL r0_wb got r%0d %h want r0 0000ffff", o.rd, o.data);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_tests++;
    if (retire_count !== 16'(retired)) begin
      n_fail++; $display("FAIL r0_retire got %0d want %0d", retire_count, retired);
    end
    dbg_addr = 4'd0; #1;
    n_tests++;
    if (dbg_data !== 32'd0) begin
      n_fail++; $display("FAIL r0_dbg got %h want 0", dbg_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dbg_timing();
    int s, es;
    logic [31:0] old_v, new_v;
    old_v = rf[8];
    issue(4'd0, 4'd8, 4'd0, 4'd0, 1'b1, 16'h1234, s, es);
    new_v = rf[8];
    dbg_addr = 4'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (dbg_data !== ((k < 3) ? old_v : new_v)) begin
        n_fail++;
        $display("FAIL dbg_timing step%0d got %h want %h", k, dbg_data, (k < 3) ? old_v : new_v);
      end
    end
    @(posedge clk); #1;
    drain();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int s, es;
    ev_t o, x;
    logic [3:0] op;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        cmd_valid = 1'b0;
        @(posedge clk); #1;
      end
      op = ($urandom_range(0, 15) == 0) ? 4'(10 + $urandom_range(0, 5))
                                        : 4'($urandom_range(0, 9));
      issue(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            16'($urandom), s, es);
      n_tests++;
      if (s !== es) begin
        n_fail++; $display("FAIL rand_stall n%0d got %0d want %0d", n, s, es);
      end
    end
    drain();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_wb_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL rand_wb got c%0d r%0d %h want c%0d r%0d %h", o.cyc, o.rd, o.data, x.cyc, x.rd, x.data);
      end
    end
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #0.5;
      n_tests++;
      if (dbg_data !== rf[i]) begin
        n_fail++; $display("FAIL rand_reg r%0d got %h want %h", i, dbg_data, rf[i]);
      end
    end
    n_tests++;
    if (retire_count !== 16'(retired) || err_illegal !== err_m) begin
      n_fail++;
      $display("FAIL rand_status got cnt=%0d err=%b want %0d/%b", retire_count, err_illegal, retired, err_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    int s, es;
    issue(4'd13, 4'd9, 4'd0, 4'd0, 1'b1, 16'h0000, s, es);
    issue(4'd0, 4'd10, 4'd0, 4'd0, 1'b1, 16'h0011, s, es);
    issue(4'd0, 4'd11, 4'd0, 4'd0, 1'b1, 16'h0022, s, es);
    n_tests++;
    if (wb_valid !== 1'b1 || wb_rd !== 4'd10) begin
      n_fail++; $display("FAIL mid_pre got v=%b rd=%0d want 1/10", wb_valid, wb_rd);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    n_tests++;
    if ({alu_operation, alu_operand1, alu_operand2} !== 68'd0) begin
      n_fail++;
      $display("FAIL mid_alu got %h %h %h want 0", alu_operation, alu_operand1, alu_operand2);
    end
    n_tests++;
    if (cmd_ready !== 1'b1 || {wb_valid, wb_rd, wb_data} !== 37'd0) begin
      n_fail++;
      $display("FAIL mid_wb got rdy=%b %b/%h/%h want 1/0", cmd_ready, wb_valid, wb_rd, wb_data);
    end
    drain();
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL mid_no_wb got %0d events want 0", obs_q.size());
    end
    n_tests++;
    if (err_illegal !== 1'b0 || retire_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_flags got err=%b cnt=%0d want 0/0", err_illegal, retire_count);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #0.5;
      n_tests++;
      if (dbg_data !== 32'd0) begin
        n_fail++; $display("FAIL mid_reg r%0d got %h want 0", i, dbg_data);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_r0_write();
    test_dbg_timing();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
